// File: rtl/axi_bus_arbiter_pkg.sv
// Shared definitions for the AXI bus arbiter: FSM state encoding,
// per-master index constants and an index-width helper.
package axi_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam int ICACHE         = 0;
    localparam int DCACHE         = 1;
    localparam int UNCACHED_LOAD  = 2;
    localparam int UNCACHED_STORE = 3;

    // Index width that stays legal for a single-master build
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_bus_arbiter_arb_pick.sv
// Winner selection: first requesting index found searching upward
// (with wrap) from the priority pointer. Returns one-hot, index and any.
module arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Rotating priority search; the first hit locks out later candidates
    always_comb begin : pick
        int               j;
        logic [IDX_W-1:0] jj;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        jj     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j  = (int'(ptr) + i) % NUM_REQ;
            jj = IDX_W'(j);
            if (!any && req[jj]) begin
                any        = 1'b1;
                onehot[jj] = 1'b1;
                idx        = jj;
            end
        end
    end

endmodule

// File: rtl/axi_bus_arbiter.sv
// AXI bus arbiter: grants one master at a time the shared AXI port,
// holds the grant while the owner requests, then waits for all open
// transactions to drain and inserts a one-cycle gap before re-arbitrating.
// Build option: define AXI_ARB_ROUND_ROBIN_EN for round-robin priority;
// otherwise fixed priority (lowest requesting index wins).
module axi_bus_arbiter
    import axi_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OUTST_W = 3,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grnt,
    output logic [IDX_W-1:0]   owner_id,
    output logic               bus_busy,
    input  logic               arvalid,
    input  logic               arready,
    input  logic               rvalid,
    input  logic               rready,
    input  logic               rlast,
    input  logic               awvalid,
    input  logic               awready,
    input  logic               bvalid,
    input  logic               bready,
    output logic [OUTST_W-1:0] outstanding,
    output logic               err
);

    localparam int CW = OUTST_W + 2;
    localparam logic signed [CW-1:0] ONE = CW'(1);
    localparam logic signed [CW-1:0] MAX = CW'((1 << OUTST_W) - 1);

    arb_state_e          state;
    logic [IDX_W-1:0]    ptr;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic signed [CW-1:0] sum;
    logic [OUTST_W-1:0]  outst_nxt;
    logic                ovf;

    arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // Pointer sits one past the last winner so that owner loses priority next
    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (state == IDLE && pick_any)
            ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
`else
    assign ptr = '0;
`endif

    // Net change of open transactions this cycle, saturating at both ends
    always_comb begin
        sum = $signed({2'b00, outstanding});
        if (arvalid && arready)         sum = sum + ONE;
        if (awvalid && awready)         sum = sum + ONE;
        if (rvalid && rready && rlast)  sum = sum - ONE;
        if (bvalid && bready)           sum = sum - ONE;
        ovf       = 1'b0;
        outst_nxt = sum[OUTST_W-1:0];
        if (sum[CW-1]) begin
            outst_nxt = '0;
            ovf       = 1'b1;
        end else if (sum > MAX) begin
            outst_nxt = MAX[OUTST_W-1:0];
            ovf       = 1'b1;
        end
    end

    // Outstanding counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            outstanding <= outst_nxt;
            if (ovf) err <= 1'b1;
        end
    end

    // Arbitration FSM with registered grant and owner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grnt     <= '0;
            owner_id <= '0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    grnt     <= pick_oh;
                    owner_id <= pick_idx;
                    state    <= GRANT;
                end
                GRANT: if (!req[owner_id]) begin
                    grnt  <= '0;
                    state <= (outst_nxt == '0) ? GAP : DRAIN;
                end
                DRAIN: if (outst_nxt == '0) state <= GAP;
                GAP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_busy = (state != IDLE);

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Scoreboard bench for axi_bus_arbiter: stimulus pushes cycle-tagged
// expectations and expected grant owners; a negedge monitor pops/compares.
module tb_axi_bus_arbiter;

    localparam int N  = 4;
    localparam int OW = 3;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  grnt;
    logic [1:0]    owner_id;
    logic          bus_busy;
    logic          arvalid = 0, arready = 0, rvalid = 0, rready = 0, rlast = 0;
    logic          awvalid = 0, awready = 0, bvalid = 0, bready = 0;
    logic [OW-1:0] outstanding;
    logic          err;

    axi_bus_arbiter #(.NUM_REQ(N), .OUTST_W(OW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grnt(grnt), .owner_id(owner_id),
        .bus_busy(bus_busy), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .bvalid(bvalid), .bready(bready),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        string         name;
        logic [N-1:0]  grnt;
        int            owner;
        logic          busy;
        logic [OW-1:0] outst;
        logic          err;
    } chk_t;

    chk_t chk_q[$];
    int   grant_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_at(input int dc, input string nm, input logic [N-1:0] g,
                             input int own, input logic b, input logic [OW-1:0] o,
                             input logic e);
        chk_t c;
        c.cyc = cyc + dc; c.name = nm; c.grnt = g; c.owner = own;
        c.busy = b; c.outst = o; c.err = e;
        chk_q.push_back(c);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: one-hot check every cycle, grant events, cycle-tagged checkpoints
    logic [N-1:0] prev_grnt = '0;
    always @(negedge clk) begin : mon
        chk_t         c;
        int           ge;
        logic [N-1:0] eg;
        if (cyc >= 1) begin
            n_cmp++;
            if ($countones(grnt) > 1) begin
                n_bad++;
                $display("FAIL onehot cyc=%0d grnt=%b required <=1 bit set", cyc, grnt);
            end
            if (grnt != '0 && prev_grnt == '0) begin
                n_cmp++;
                if (grant_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_grant cyc=%0d grnt=%b required none", cyc, grnt);
                end else begin
                    ge = grant_q.pop_front();
                    eg = '0;
                    eg[ge] = 1'b1;
                    if (grnt !== eg || int'(owner_id) != ge) begin
                        n_bad++;
                        $display("FAIL grant_order cyc=%0d grnt=%b owner=%0d required grnt=%b owner=%0d",
                                 cyc, grnt, owner_id, eg, ge);
                    end
                end
            end
            prev_grnt = grnt;
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s stale at cyc=%0d required cyc=%0d", c.name, cyc, c.cyc);
            end else if (grnt !== c.grnt || bus_busy !== c.busy || outstanding !== c.outst ||
                         err !== c.err || (c.owner >= 0 && int'(owner_id) != c.owner)) begin
                n_bad++;
                $display("FAIL %s cyc=%0d got grnt=%b own=%0d busy=%b out=%0d err=%b required grnt=%b own=%0d busy=%b out=%0d err=%b",
                         c.name, cyc, grnt, owner_id, bus_busy, outstanding, err,
                         c.grnt, c.owner, c.busy, c.outst, c.err);
            end
        end
    end

    initial begin : stim
        int cnt [N];
        int t;
        foreach (cnt[i]) cnt[i] = 0;

        // Reset state
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        expect_at(1, "reset", 4'b0000, 0, 0, 0, 0);
        step();

        // 1-cycle grant latency, then gap of two cycles before next grant to master 3
        grant_q.push_back(1);
        grant_q.push_back(3);
        req = 4'b1010;
        expect_at(1, "grant_m1", 4'b0010, 1, 1, 0, 0);
        step();
        req = 4'b1000;
        expect_at(1, "gap_a",    4'b0000, 1, 1, 0, 0);
        expect_at(2, "idle_a",   4'b0000, 1, 0, 0, 0);
        expect_at(3, "grant_m3", 4'b1000, 3, 1, 0, 0);
        step(3);

        // Owner 3: AW then release; B four cycles later -> DRAIN, GAP, IDLE
        req = 4'b0000; awvalid = 1; awready = 1;
        for (int d = 1; d <= 4; d++) expect_at(d, "drain", 4'b0000, 3, 1, 1, 0);
        expect_at(5, "gap_b",  4'b0000, 3, 1, 0, 0);
        expect_at(6, "idle_b", 4'b0000, 3, 0, 0, 0);
        step();
        awvalid = 0; awready = 0;
        step(3);
        bvalid = 1; bready = 1;
        step();
        bvalid = 0; bready = 0;
        step(2);

        // Counter: simultaneous AR + R-last, R without last, underflow
        arvalid = 1; arready = 1;
        expect_at(1, "ar_only", 4'b0000, 3, 0, 1, 0);
        step();
        rvalid = 1; rready = 1; rlast = 1;
        expect_at(1, "ar_and_rlast", 4'b0000, 3, 0, 1, 0);
        step();
        arvalid = 0; arready = 0;
        expect_at(1, "rlast_only", 4'b0000, 3, 0, 0, 0);
        step();
        arvalid = 1; arready = 1; rlast = 0;
        expect_at(1, "r_no_last", 4'b0000, 3, 0, 1, 0);
        step();
        arvalid = 0; arready = 0; rvalid = 0; rready = 0;
        bvalid = 1; bready = 1;
        expect_at(1, "b_to_zero", 4'b0000, 3, 0, 0, 0);
        step();
        expect_at(1, "underflow", 4'b0000, 3, 0, 0, 1);
        step();
        bvalid = 0; bready = 0;
        expect_at(3, "err_sticky", 4'b0000, 3, 0, 0, 1);
        step(3);

        // Reset mid-GRANT with two open transactions
        grant_q.push_back(0);
        req = 4'b0001;
        arvalid = 1; arready = 1; awvalid = 1; awready = 1;
        expect_at(1, "grant_out2", 4'b0001, 0, 1, 2, 1);
        step();
        arvalid = 0; arready = 0; awvalid = 0; awready = 0;
        rst_n = 1'b0;
        expect_at(1, "mid_reset", 4'b0000, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        req = 4'b1111;
        grant_q.push_back(0);
        expect_at(1, "post_rst_m0", 4'b0001, 0, 1, 0, 0);
        step();
        req = 4'b0000;
        expect_at(1, "gap_e",  4'b0000, 0, 1, 0, 0);
        expect_at(2, "idle_e", 4'b0000, 0, 0, 0, 0);
        step(2);

        // Overflow: +2 per cycle saturates at 7 and sets err
        arvalid = 1; arready = 1; awvalid = 1; awready = 1;
        expect_at(1, "ovf_2", 4'b0000, 0, 0, 2, 0);
        expect_at(2, "ovf_4", 4'b0000, 0, 0, 4, 0);
        expect_at(3, "ovf_6", 4'b0000, 0, 0, 6, 0);
        expect_at(4, "ovf_sat", 4'b0000, 0, 0, 7, 1);
        step(4);
        arvalid = 0; arready = 0; awvalid = 0; awready = 0;

        // All masters requesting, each releases after three grant cycles
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) grant_q.push_back(RR ? (k % N) : 0);
        req = 4'b1111;
        t = 0;
        while (grant_q.size() > 0 && t < 80) begin
            step();
            t++;
            for (int i = 0; i < N; i++) begin
                if (grnt[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 3) begin
                        req[i] = 1'b0;
                        cnt[i] = 0;
                    end
                end else begin
                    req[i] = 1'b1;
                end
            end
        end
        if (grant_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_timeout remaining=%0d required 0", grant_q.size());
        end
        req = 4'b0000;
        step(8);

        t = 0;
        while (chk_q.size() > 0 && t < 20) begin
            step();
            t++;
        end
        if (chk_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL checkpoints_left remaining=%0d required 0", chk_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_bus_arbiter.md
AXI_BUS_ARBITER -- requirements
Module: axi_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of AXI masters sharing the one external AXI port.
REQ-002 SHALL have parameter OUTST_W, default 3, width of the outstanding-transaction counter.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-master bus request; held high for the whole transaction.
REQ-006 SHALL have port grnt  output  NUM_REQ  one-hot grant, registered.
REQ-007 SHALL have port owner_id  output  clog2(NUM_REQ)  index of the current or last owner, registered.
REQ-008 SHALL have port bus_busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have ports arvalid, arready, rvalid, rready, rlast, awvalid, awready, bvalid, bready  input  1 each  shared-bus handshake monitors.
REQ-010 SHALL have port outstanding  output  OUTST_W  count of open bus transactions.
REQ-011 SHALL have port err  output  1  sticky counter overflow/underflow flag.

Function
REQ-012 SHALL implement states IDLE, GRANT, DRAIN, GAP.
REQ-013 IDLE: if any req bit is high, SHALL select a winner, drive grnt[winner]=1 and owner_id=winner from the next edge, and go to GRANT; grant latency from req is exactly 1 cycle.
REQ-014 GRANT: SHALL hold grnt unchanged while req[owner_id]=1; requests from other masters SHALL NOT pre-empt.
REQ-015 GRANT with req[owner_id]=0: SHALL clear grnt; next state GAP if next-cycle outstanding is 0, otherwise DRAIN.
REQ-016 DRAIN: grnt=0; SHALL go to GAP in the cycle after outstanding reaches 0.
REQ-017 GAP: grnt=0 for exactly one cycle, then IDLE; minimum gap between two grants is therefore 2 cycles.
REQ-018 outstanding SHALL count +1 per AR handshake (arvalid&arready), +1 per AW handshake, -1 per R handshake with rlast, and -1 per B handshake; simultaneous events SHALL be summed in the same cycle (range -2..+2).
REQ-019 If a net increment would exceed 2^OUTST_W-1, outstanding SHALL saturate and err SHALL set; if a net decrement would go below 0, outstanding SHALL clamp at 0 and err SHALL set.
REQ-020 err SHALL remain set until reset; it SHALL NOT affect arbitration.
REQ-021 A req bit that rises and falls while another master owns the bus SHALL be lost with no recorded state.
REQ-022 grnt SHALL never have more than one bit set.

Reset
REQ-023 When rst_n=0 at an edge: state=IDLE, grnt=0, owner_id=0, outstanding=0, err=0, and the round-robin pointer is set so that master 0 has highest priority; this applies mid-transaction too.
REQ-024 bus_busy SHALL be 0 in the first cycle after reset.

Configuration
REQ-025 Macro AXI_ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first requesting index searched upward from (last owner_id+1) mod NUM_REQ.
REQ-026 Macro AXI_ARB_ROUND_ROBIN_EN undefined: fixed priority SHALL apply, with the lowest requesting index winning; no pointer register.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1, DRAIN=2, GAP=3) and the per-master index constants: ICACHE=0, DCACHE=1, UNCACHED_LOAD=2, UNCACHED_STORE=3.
REQ-028 Winner selection SHALL be one sub-module, arb_pick, which takes the req vector and the priority pointer and returns a one-hot vector plus an index.

Verification
REQ-029 Reset, then req=4'b1010 at cycle 0 -> grnt=4'b0010 and owner_id=1 at cycle 1; grnt=4'b1000 after master 1 drops req and 2 further cycles elapse (round robin); with the macro undefined the second grant also goes to master 3, because master 1 is no longer requesting.
REQ-030 Owner 3 issues an AW handshake, drops req, and B arrives 4 cycles later -> state DRAIN, outstanding=1 for 4 cycles, then GAP, then IDLE; grnt stays 0 throughout.
REQ-031 R handshake with rlast and AR handshake in the same cycle at outstanding=1 -> outstanding stays 1 and err=0.
REQ-032 B handshake at outstanding=0 -> outstanding=0, err=1 and stays 1 until rst_n=0.
REQ-033 rst_n=0 while in GRANT with outstanding=2 -> next cycle grnt=0, outstanding=0, bus_busy=0, and the next grant goes to master 0 if it is requesting.
REQ-034 All requesters high continuously for 40 cycles, each holding req for 3 cycles after grant -> grants cycle 0,1,2,3,0...; grnt is never multi-hot.
